uart_rx_edge_sampler: RTL and testbench

Bit-timing and data-recovery front end of the UART receiver. It counts oversampling clock edges within each bit and bits within each frame, and it recovers each bit by majority vote of three samples around mid-bit. Its outputs `edge_cnt`, `bit_cnt` and `sampled_bit` feed the RX control FSM and the start, parity and stop checkers. It consumes the FSM's `enable` and `dat_samp_en`.

---
 rtl/uart_rx_edge_sampler.sv | 123 ++++++++++++
 tb/tb_uart_rx_edge_sampler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_edge_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_edge_sampler: UART RX bit timing and 3-sample majority recovery    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx_edge_sampler #(
  parameter int EDGE_W  = 5,
  parameter int BIT_W   = 4,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               enable,
  input  logic               dat_samp_en,
  output logic [EDGE_W-1:0]  edge_cnt,
  output logic [BIT_W-1:0]   bit_cnt,
  output logic               sampled_bit,
  output logic               samp_valid
);

  localparam logic [PRESC_W-1:0] c_p_min   = PRESC_W'(8);
  localparam logic [PRESC_W-1:0] c_p_max   = PRESC_W'(32);
  localparam logic [PRESC_W-1:0] c_p_one   = PRESC_W'(1);
  localparam logic [EDGE_W-1:0]  c_e_zero  = '0;
  localparam logic [EDGE_W-1:0]  c_e_one   = EDGE_W'(1);
  localparam logic [EDGE_W-1:0]  c_e_two   = EDGE_W'(2);
  localparam logic [BIT_W-1:0]   c_b_zero  = '0;
  localparam logic [BIT_W-1:0]   c_b_one   = BIT_W'(1);
  localparam logic [BIT_W-1:0]   c_b_max   = '1;

  logic [PRESC_W-1:0] r_presc;
  logic [EDGE_W-1:0]  r_edge_cnt;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_sampled_bit;
  logic               r_samp_valid;
  logic               r_s0;
  logic               r_s1;
  logic               r_ok;

  logic [PRESC_W-1:0] w_presc_clamped;
  logic [EDGE_W-1:0]  w_last;
  logic [EDGE_W-1:0]  w_mid;
  logic [EDGE_W-1:0]  w_pt0;
  logic [EDGE_W-1:0]  w_pt1;
  logic               w_wrap;
  logic               w_majority;

  always_comb begin
    w_presc_clamped = Prescale;
    if (Prescale < c_p_min) begin
      w_presc_clamped = c_p_min;
    end else if (Prescale > c_p_max) begin
      w_presc_clamped = c_p_max;
    end
  end

  // P is at most 32, so P-1 and P>>1 always fit in the edge counter width.
  assign w_last     = EDGE_W'(r_presc - c_p_one);
  assign w_mid      = EDGE_W'(r_presc >> 1);
  assign w_pt0      = w_mid - c_e_two;
  assign w_pt1      = w_mid - c_e_one;
  assign w_wrap     = (r_edge_cnt == w_last);
  assign w_majority = (r_s0 & r_s1) | (r_s0 & RX_IN) | (r_s1 & RX_IN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc       <= c_p_min;
      r_edge_cnt    <= c_e_zero;
      r_bit_cnt     <= c_b_zero;
      r_sampled_bit <= 1'b1;
      r_samp_valid  <= 1'b0;
      r_s0          <= 1'b1;
      r_s1          <= 1'b1;
      r_ok          <= 1'b0;
    end else begin
      r_samp_valid <= 1'b0;
      if (!enable) begin
        r_presc    <= w_presc_clamped;
        r_edge_cnt <= c_e_zero;
        r_bit_cnt  <= c_b_zero;
        r_s0       <= 1'b1;
        r_s1       <= 1'b1;
        r_ok       <= 1'b0;
      end else begin
        if (w_wrap) begin
          r_edge_cnt <= c_e_zero;
          if (r_bit_cnt != c_b_max) begin
            r_bit_cnt <= r_bit_cnt + c_b_one;
          end
        end else begin
          r_edge_cnt <= r_edge_cnt + c_e_one;
        end

        // r_ok records that sampling stayed allowed across all three points.
        if (r_edge_cnt == w_pt0) begin
          r_ok <= dat_samp_en;
          if (dat_samp_en) begin
            r_s0 <= RX_IN;
          end
        end
        if (r_edge_cnt == w_pt1) begin
          r_ok <= r_ok & dat_samp_en;
          if (dat_samp_en) begin
            r_s1 <= RX_IN;
          end
        end
        if ((r_edge_cnt == w_mid) && r_ok && dat_samp_en) begin
          r_sampled_bit <= w_majority;
          r_samp_valid  <= 1'b1;
        end
      end
    end
  end

  assign edge_cnt    = r_edge_cnt;
  assign bit_cnt     = r_bit_cnt;
  assign sampled_bit = r_sampled_bit;
  assign samp_valid  = r_samp_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_edge_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_edge_sampler: directed bench for uart_rx_edge_sampler           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_rx_edge_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       enable = 1'b0;
  logic       dat_samp_en = 1'b0;
  logic [4:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       samp_valid;

  int vectors = 0;
  int errors  = 0;

  uart_rx_edge_sampler #(.EDGE_W(5), .BIT_W(4), .PRESC_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .enable      (enable),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sampled_bit (sampled_bit),
    .samp_valid  (samp_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [9:0] frame;

  initial begin
    // Reset state
    tick();
    check("rst_edge", 32'(edge_cnt), 0);
    check("rst_bit", 32'(bit_cnt), 0);
    check("rst_sbit", 32'(sampled_bit), 1);
    check("rst_valid", 32'(samp_valid), 0);
    rst = 1'b0;

    // Clean frame: start, 0x5A LSB first, stop at P=8
    frame = {1'b1, 8'h5A, 1'b0};
    Prescale = 6'd8;
    tick();
    enable = 1'b1;
    dat_samp_en = 1'b1;
    for (int b = 0; b < 10; b++) begin
      for (int e = 0; e < 8; e++) begin
        RX_IN = frame[b];
        tick();
        check("f_edge", 32'(edge_cnt), 32'((e + 1) % 8));
        check("f_bit", 32'(bit_cnt), 32'(b + ((e == 7) ? 1 : 0)));
        check("f_valid", 32'(samp_valid), 32'((e == 4) ? 1 : 0));
        if (e == 4) check("f_sbit", 32'(sampled_bit), 32'(frame[b]));
      end
    end
    check("f_end_bit", 32'(bit_cnt), 10);
    check("f_end_edge", 32'(edge_cnt), 0);

    // Glitch rejection, then a two-sample low, then a discarded bit
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int e = 0; e < 8; e++) begin
      RX_IN = (e == 3) ? 1'b0 : 1'b1;
      tick();
      if (e == 4) begin
        check("g1_valid", 32'(samp_valid), 1);
        check("g1_sbit", 32'(sampled_bit), 1);
      end
    end
    for (int e = 0; e < 8; e++) begin
      RX_IN = (e == 2 || e == 3) ? 1'b0 : 1'b1;
      tick();
      if (e == 4) begin
        check("g2_valid", 32'(samp_valid), 1);
        check("g2_sbit", 32'(sampled_bit), 0);
      end
    end
    for (int e = 0; e < 8; e++) begin
      RX_IN = 1'b1;
      dat_samp_en = (e == 3) ? 1'b0 : 1'b1;
      tick();
      if (e == 4) begin
        check("g3_valid", 32'(samp_valid), 0);
        check("g3_sbit", 32'(sampled_bit), 0);
      end
    end

    // Wrap and saturation at P=16 with sampling off
    enable = 1'b0;
    dat_samp_en = 1'b0;
    Prescale = 6'd16;
    tick();
    enable = 1'b1;
    for (int i = 1; i <= 272; i++) begin
      tick();
      check("w_edge", 32'(edge_cnt), 32'(i % 16));
      check("w_bit", 32'(bit_cnt), 32'((i / 16 > 15) ? 15 : i / 16));
      check("w_valid", 32'(samp_valid), 0);
    end
    check("w_sbit_hold", 32'(sampled_bit), 0);

    // Enable drop mid-frame at bit 3, edge 6
    enable = 1'b0;
    Prescale = 6'd8;
    tick();
    enable = 1'b1;
    dat_samp_en = 1'b1;
    RX_IN = 1'b0;
    ticks(30);
    check("d_edge_pre", 32'(edge_cnt), 6);
    check("d_bit_pre", 32'(bit_cnt), 3);
    RX_IN = 1'b1;
    enable = 1'b0;
    tick();
    check("d_edge", 32'(edge_cnt), 0);
    check("d_bit", 32'(bit_cnt), 0);
    check("d_valid", 32'(samp_valid), 0);
    check("d_sbit", 32'(sampled_bit), 0);

    // Enable falling on the wrap cycle
    enable = 1'b1;
    dat_samp_en = 1'b0;
    ticks(7);
    check("dw_edge_pre", 32'(edge_cnt), 7);
    enable = 1'b0;
    tick();
    check("dw_edge", 32'(edge_cnt), 0);
    check("dw_bit", 32'(bit_cnt), 0);

    // Prescale clamp low
    Prescale = 6'd5;
    tick();
    enable = 1'b1;
    ticks(7);
    check("cl_edge7", 32'(edge_cnt), 7);
    tick();
    check("cl_edge0", 32'(edge_cnt), 0);
    check("cl_bit1", 32'(bit_cnt), 1);

    // Prescale clamp high
    enable = 1'b0;
    Prescale = 6'd40;
    tick();
    enable = 1'b1;
    ticks(31);
    check("ch_edge31", 32'(edge_cnt), 31);
    tick();
    check("ch_edge0", 32'(edge_cnt), 0);
    check("ch_bit1", 32'(bit_cnt), 1);

    // Prescale frozen while enabled
    enable = 1'b0;
    Prescale = 6'd8;
    tick();
    enable = 1'b1;
    ticks(16);
    check("fz_bit2", 32'(bit_cnt), 2);
    Prescale = 6'd16;
    ticks(7);
    check("fz_edge7", 32'(edge_cnt), 7);
    tick();
    check("fz_edge0", 32'(edge_cnt), 0);
    check("fz_bit3", 32'(bit_cnt), 3);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    ticks(15);
    check("fz_edge15", 32'(edge_cnt), 15);
    tick();
    check("fz_wrap16", 32'(edge_cnt), 0);
    check("fz_bit1", 32'(bit_cnt), 1);

    // Reset mid-frame while sampled_bit is 0
    enable = 1'b0;
    Prescale = 6'd8;
    tick();
    enable = 1'b1;
    dat_samp_en = 1'b1;
    RX_IN = 1'b0;
    ticks(32);
    check("r_bit_pre", 32'(bit_cnt), 4);
    check("r_sbit_pre", 32'(sampled_bit), 0);
    Prescale = 6'd16;
    rst = 1'b1;
    tick();
    check("r_edge", 32'(edge_cnt), 0);
    check("r_bit", 32'(bit_cnt), 0);
    check("r_sbit", 32'(sampled_bit), 1);
    check("r_valid", 32'(samp_valid), 0);
    rst = 1'b0;
    dat_samp_en = 1'b0;
    ticks(7);
    check("r_p8_edge7", 32'(edge_cnt), 7);
    tick();
    check("r_p8_wrap", 32'(edge_cnt), 0);
    check("r_p8_bit1", 32'(bit_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
